// File: rtl/load_scoreboard.sv
// rtl/load_scoreboard.sv - per-register pending-write scoreboard for long-latency loads
//
// Purpose: tracks in-flight long-latency register writes (loads) per destination
// register and stalls decode when a source operand is still pending, or when an
// issuing writer cannot be accepted.
//
// Ports:
//   clk            - single clock, all state updates on rising edge
//   rst_n          - asynchronous active-low reset
//   issue_valid    - a long-latency writer issues this cycle
//   issue_rd_addr  - destination register of the issuing writer
//   wb_valid       - a tracked writer completes writeback this cycle
//   wb_rd_addr     - destination register of the completing writer
//   flush_all      - clear all tracking state
//   id_rs1_addr    - decode source register 1
//   id_rs2_addr    - decode source register 2
//   id_uses_rs1    - decode actually reads rs1
//   id_uses_rs2    - decode actually reads rs2
//   stall_pipeline - decode must hold
//   issue_ready    - an issue this cycle would be accepted
//   outstanding    - total count of tracked in-flight writes
//   err_underflow  - sticky: writeback seen for a register with nothing pending

module load_scoreboard #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue_valid,
    input  logic [4:0] issue_rd_addr,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd_addr,
    input  logic       flush_all,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    output logic       stall_pipeline,
    output logic       issue_ready,
    output logic [3:0] outstanding,
    output logic       err_underflow
);

    localparam logic [3:0]           MAX_OUT = 4'(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0] CNT_SAT = {CNT_WIDTH{1'b1}};

    // Entry 0 exists only to keep indexing simple; it is never incremented,
    // so x0 always reads as "nothing pending".
    logic [CNT_WIDTH-1:0] cnt [32];

    logic        issue_cnt_sat;
    logic        issue_accept;
    logic        wb_dec;
    logic        wb_underflow;
    logic [31:0] inc_vec;
    logic [31:0] dec_vec;
    logic [3:0]  outstanding_nxt;

    always_comb begin
        issue_cnt_sat = (cnt[issue_rd_addr] == CNT_SAT);
        issue_ready   = (outstanding != MAX_OUT) && !issue_cnt_sat;

        // An accepted issue to x0 is swallowed: it is neither counted
        // per register nor in the outstanding total.
        issue_accept  = issue_valid && issue_ready && (issue_rd_addr != 5'd0);
        wb_dec        = wb_valid && (wb_rd_addr != 5'd0) && (cnt[wb_rd_addr] != '0);
        wb_underflow  = wb_valid && (wb_rd_addr != 5'd0) && (cnt[wb_rd_addr] == '0);

        inc_vec = 32'd0;
        dec_vec = 32'd0;
        if (issue_accept) begin
            inc_vec[issue_rd_addr] = 1'b1;
        end
        if (wb_dec) begin
            dec_vec[wb_rd_addr] = 1'b1;
        end

        // Same-rd issue+writeback cancels naturally: +1 and -1 on one entry
        // and on the total.
        outstanding_nxt = outstanding + {3'd0, issue_accept} - {3'd0, wb_dec};

        // Stall uses registered counters only; a writeback this cycle does not
        // release the stall until the following cycle.
        stall_pipeline = (id_uses_rs1 && (cnt[id_rs1_addr] != '0)) ||
                         (id_uses_rs2 && (cnt[id_rs2_addr] != '0)) ||
                         (issue_valid && !issue_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= '0;
            end
            outstanding <= 4'd0;
        end else if (flush_all) begin
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= '0;
            end
            outstanding <= 4'd0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= cnt[i] + CNT_WIDTH'(inc_vec[i]) - CNT_WIDTH'(dec_vec[i]);
            end
            outstanding <= outstanding_nxt;
        end
    end

    // Sticky error survives flush; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_underflow <= 1'b0;
        end else if (wb_underflow) begin
            err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_load_scoreboard.sv
// tb/tb_load_scoreboard.sv - scoreboard-checked directed bench for load_scoreboard

module tb_load_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       issue_valid;
    logic [4:0] issue_rd_addr;
    logic       wb_valid;
    logic [4:0] wb_rd_addr;
    logic       flush_all;
    logic [4:0] id_rs1_addr;
    logic [4:0] id_rs2_addr;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       stall_pipeline;
    logic       issue_ready;
    logic [3:0] outstanding;
    logic       err_underflow;

    typedef struct {
        string      name;
        logic       stall;
        logic       ready;
        logic [3:0] outs;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    load_scoreboard #(.MAX_OUTSTANDING(4), .CNT_WIDTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid    (issue_valid),
        .issue_rd_addr  (issue_rd_addr),
        .wb_valid       (wb_valid),
        .wb_rd_addr     (wb_rd_addr),
        .flush_all      (flush_all),
        .id_rs1_addr    (id_rs1_addr),
        .id_rs2_addr    (id_rs2_addr),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .stall_pipeline (stall_pipeline),
        .issue_ready    (issue_ready),
        .outstanding    (outstanding),
        .err_underflow  (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input string field, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s.%s actual=%0d expected=%0d", name, field, act, exp);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, mid-cycle, against the
    // expectation queued for the inputs driven in that cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "stall",       int'(stall_pipeline), int'(e.stall));
            chk(e.name, "ready",       int'(issue_ready),    int'(e.ready));
            chk(e.name, "outstanding", int'(outstanding),    int'(e.outs));
            chk(e.name, "err",         int'(err_underflow),  int'(e.err));
        end
    end

    // Drives one cycle of inputs just after a rising edge, queues the expected
    // outputs for that cycle, then advances to just after the next rising edge.
    task automatic step(input logic rstv,
                        input logic iv, input logic [4:0] ird,
                        input logic wv, input logic [4:0] wrd,
                        input logic fl,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic st, input logic rdy,
                        input logic [3:0] outs, input logic err,
                        input string name);
        exp_t e;
        rst_n         = rstv;
        issue_valid   = iv;
        issue_rd_addr = ird;
        wb_valid      = wv;
        wb_rd_addr    = wrd;
        flush_all     = fl;
        id_rs1_addr   = rs1;
        id_uses_rs1   = u1;
        id_rs2_addr   = rs2;
        id_uses_rs2   = u2;
        e.name  = name;
        e.stall = st;
        e.ready = rdy;
        e.outs  = outs;
        e.err   = err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        issue_valid = 0; issue_rd_addr = 0; wb_valid = 0; wb_rd_addr = 0;
        flush_all = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        repeat (2) @(posedge clk);
        #1;
        //    rst iv ird wv wrd fl rs1 u1 rs2 u2  st rdy out err
        step(0, 0, 0,  0, 0,  0, 0,  0, 0,  0,  0, 1,  0,  0, "reset");

        // load-use on x5
        step(1, 1, 5,  0, 0,  0, 0,  0, 0,  0,  0, 1,  0,  0, "lu_issue");
        step(1, 0, 0,  0, 0,  0, 5,  1, 0,  0,  1, 1,  1,  0, "lu_stall");
        step(1, 0, 0,  1, 5,  0, 5,  1, 0,  0,  1, 1,  1,  0, "lu_wb_no_bypass");
        step(1, 0, 0,  0, 0,  0, 5,  1, 0,  0,  0, 1,  0,  0, "lu_release");

        // fill to MAX_OUTSTANDING
        step(1, 1, 1,  0, 0,  0, 0,  0, 0,  0,  0, 1,  0,  0, "full_i1");
        step(1, 1, 2,  0, 0,  0, 0,  0, 0,  0,  0, 1,  1,  0, "full_i2");
        step(1, 1, 3,  0, 0,  0, 0,  0, 0,  0,  0, 1,  2,  0, "full_i3");
        step(1, 1, 4,  0, 0,  0, 0,  0, 0,  0,  0, 1,  3,  0, "full_i4");
        step(1, 1, 6,  0, 0,  0, 0,  0, 0,  0,  1, 0,  4,  0, "full_refuse");
        step(1, 0, 6,  0, 0,  0, 0,  0, 0,  0,  0, 0,  4,  0, "full_nochange");
        step(1, 0, 6,  1, 1,  0, 0,  0, 0,  0,  0, 0,  4,  0, "full_wb1");
        step(1, 0, 6,  0, 0,  0, 0,  0, 0,  0,  0, 1,  3,  0, "full_ready_again");
        step(1, 0, 0,  1, 2,  0, 0,  0, 0,  0,  0, 1,  3,  0, "full_wb2");
        step(1, 0, 0,  1, 3,  0, 0,  0, 0,  0,  0, 1,  2,  0, "full_wb3");
        step(1, 0, 0,  1, 4,  0, 0,  0, 0,  0,  0, 1,  1,  0, "full_wb4");

        // WAW saturation on x7 (depth 3)
        step(1, 1, 7,  0, 0,  0, 0,  0, 0,  0,  0, 1,  0,  0, "waw_i1");
        step(1, 1, 7,  0, 0,  0, 0,  0, 0,  0,  0, 1,  1,  0, "waw_i2");
        step(1, 1, 7,  0, 0,  0, 0,  0, 0,  0,  0, 1,  2,  0, "waw_i3");
        step(1, 1, 7,  0, 0,  0, 0,  0, 7,  1,  1, 0,  3,  0, "waw_refuse");
        step(1, 0, 0,  1, 7,  0, 0,  0, 7,  1,  1, 1,  3,  0, "waw_wb1");
        step(1, 0, 0,  1, 7,  0, 0,  0, 7,  1,  1, 1,  2,  0, "waw_wb2");
        step(1, 0, 0,  1, 7,  0, 0,  0, 7,  1,  1, 1,  1,  0, "waw_wb3");
        step(1, 0, 0,  0, 0,  0, 0,  0, 7,  1,  0, 1,  0,  0, "waw_release");

        // simultaneous issue+wb on x9, and x0 never tracked
        step(1, 1, 9,  0, 0,  0, 0,  0, 0,  0,  0, 1,  0,  0, "sim_i9");
        step(1, 1, 9,  1, 9,  0, 0,  0, 0,  0,  0, 1,  1,  0, "sim_iw9");
        step(1, 0, 0,  0, 0,  0, 9,  1, 0,  0,  1, 1,  1,  0, "sim_still_pending");
        step(1, 1, 0,  0, 0,  0, 0,  1, 0,  0,  0, 1,  1,  0, "x0_issue");
        step(1, 0, 0,  0, 0,  0, 0,  1, 0,  0,  0, 1,  1,  0, "x0_not_counted");
        step(1, 0, 0,  1, 9,  0, 0,  0, 0,  0,  0, 1,  1,  0, "sim_wb9");

        // underflow is sticky; flush overrides same-cycle issue/wb
        step(1, 0, 0,  1, 3,  0, 0,  0, 0,  0,  0, 1,  0,  0, "uf_wb3");
        step(1, 0, 0,  0, 0,  0, 0,  0, 0,  0,  0, 1,  0,  1, "uf_sticky");
        step(1, 1, 10, 0, 0,  0, 0,  0, 0,  0,  0, 1,  0,  1, "fl_i10");
        step(1, 1, 11, 0, 0,  0, 0,  0, 0,  0,  0, 1,  1,  1, "fl_i11");
        step(1, 1, 12, 0, 0,  0, 0,  0, 0,  0,  0, 1,  2,  1, "fl_i12");
        step(1, 1, 13, 1, 10, 1, 10, 1, 0,  0,  1, 1,  3,  1, "fl_flush");
        step(1, 0, 0,  0, 0,  0, 10, 1, 0,  0,  0, 1,  0,  1, "fl_cleared");

        // asynchronous reset between edges while stalled
        step(1, 1, 5,  0, 0,  0, 0,  0, 0,  0,  0, 1,  0,  1, "ar_issue");
        step(1, 0, 0,  0, 0,  0, 5,  1, 0,  0,  1, 1,  1,  1, "ar_stalled");
        step(0, 0, 0,  0, 0,  0, 5,  1, 0,  0,  0, 1,  0,  0, "ar_async_clear");
        step(1, 0, 0,  0, 0,  0, 5,  1, 0,  0,  0, 1,  0,  0, "ar_released");
        step(1, 1, 5,  0, 0,  0, 0,  0, 0,  0,  0, 1,  0,  0, "ar_reissue");
        step(1, 0, 0,  0, 0,  0, 5,  1, 0,  0,  1, 1,  1,  0, "ar_restall");

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_scoreboard.md
LOAD_SCOREBOARD -- requirements
Module: load_scoreboard

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of in-flight register writes tracked in total (range 1-15).
REQ-002 SHALL have parameter CNT_WIDTH, default 2, meaning the width of each per-register pending counter (WAW depth = 2^CNT_WIDTH-1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port issue_valid  input  1  a long-latency writer (load) issues this cycle.
REQ-006 SHALL have port issue_rd_addr  input  5  destination register of the issuing writer.
REQ-007 SHALL have port wb_valid  input  1  a tracked writer completes writeback this cycle.
REQ-008 SHALL have port wb_rd_addr  input  5  destination register of the completing writer.
REQ-009 SHALL have port flush_all  input  1  clear all tracking state (memory side already drained).
REQ-010 SHALL have ports id_rs1_addr, id_rs2_addr  input  5 each  source registers of the decoding instruction.
REQ-011 SHALL have ports id_uses_rs1, id_uses_rs2  input  1 each  source operand is actually read.
REQ-012 SHALL have port stall_pipeline  output  1  decode must hold: source pending or issue not acceptable.
REQ-013 SHALL have port issue_ready  output  1  an issue this cycle would be accepted.
REQ-014 SHALL have port outstanding  output  4  total count of tracked in-flight writes.
REQ-015 SHALL have port err_underflow  output  1  sticky flag: writeback seen for a register with count 0.

Function
REQ-016 SHALL hold one CNT_WIDTH-bit pending counter per register x1-x31; x0 SHALL never be tracked (issue or wb to x0 ignored, never counted).
REQ-017 SHALL accept an issue only when issue_valid && issue_ready; accepted issue increments counter[rd] and outstanding at the next edge.
REQ-018 SHALL drive issue_ready = 0 when outstanding == MAX_OUTSTANDING or counter[issue_rd_addr] is saturated; otherwise 1 (combinational from registered state).
REQ-019 SHALL, on wb_valid with counter[rd] > 0, decrement counter[rd] and outstanding at the next edge.
REQ-020 SHALL, on wb_valid with counter[rd] == 0 (rd != 0), leave state unchanged and set err_underflow, which stays set until reset.
REQ-021 SHALL, on simultaneous accepted issue and valid writeback to the same rd, leave counter[rd] and outstanding unchanged (net zero); to different rds, apply both.
REQ-022 SHALL compute stall_pipeline combinationally from registered counters only (no same-cycle wb bypass): 1 if (id_uses_rs1 && counter[rs1] != 0) or (id_uses_rs2 && counter[rs2] != 0) or (issue_valid && !issue_ready).
REQ-023 SHALL therefore release a stall one cycle after the writeback that clears the last pending count.
REQ-024 SHALL, on flush_all, clear all counters and outstanding at the next edge, overriding any same-cycle issue or writeback; err_underflow is unaffected.
REQ-025 SHALL never let outstanding exceed MAX_OUTSTANDING or wrap below 0.

Reset
REQ-026 SHALL, while rst_n is low, asynchronously force all counters and outstanding to 0 and err_underflow to 0, giving stall_pipeline = 0 (with issue_valid = 0) and issue_ready = 1.
REQ-027 SHALL resume normal operation on the first rising clk edge after rst_n deasserts; reset mid-operation discards all pending state.

Verification
REQ-028 SHALL verify load-use: issue rd=5, next cycle id_rs1=5 uses_rs1=1 -> stall=1; wb rd=5 in cycle N -> stall=0 in N+1, outstanding back to 0.
REQ-029 SHALL verify full: 4 issues to rd=1,2,3,4 -> outstanding=4, issue_ready=0, 5th issue_valid gives stall=1 and no count change; one wb -> issue_ready=1 next cycle.
REQ-030 SHALL verify WAW: 3 issues to rd=7 -> 4th to rd=7 refused (issue_ready=0); 3 wbs to rd=7 required before id_rs2=7 unstalls.
REQ-031 SHALL verify simultaneous issue and wb to rd=9 with counter[9]=1 -> counter stays 1, outstanding unchanged; x0 issue -> outstanding unchanged, no stall for rs1=0.
REQ-032 SHALL verify underflow and flush: wb rd=3 with nothing pending -> err_underflow=1 sticky; flush_all with outstanding=3 -> 0 next cycle, err_underflow still 1.
REQ-033 SHALL verify asynchronous reset asserted mid-stall between clock edges -> stall_pipeline=0 and outstanding=0 immediately, before the next edge.
